// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional encoder.
// Holds generator polynomials, tail length, symbol type and FSM states.
package viterbi_pkg;

  localparam int         K        = 7;
  localparam logic [6:0] G0       = 7'o171;
  localparam logic [6:0] G1       = 7'o133;
  localparam int         TAIL_LEN = 6;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// K=7 shift register and parity logic; sym_o is combinational from sr and bit_i.
// Ports: clk, rst (async active-low), shift_en, bit_i, sym_o {g0,g1}.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       bit_i,
  output logic [1:0] sym_o
);

  logic [K-2:0] sr_q;
  logic [K-2:0] sr_d;
  logic [K-1:0] v;

  // v places the new bit at the MSB and the oldest bit at the LSB
  always_comb begin
    v[K-1] = bit_i;
    for (int i = 0; i < K-1; i++) begin
      v[K-2-i] = sr_q[i];
    end
  end

  assign sym_o = {^(v & G0), ^(v & G1)};

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = {sr_q[K-3:0], bit_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/conv_enc_framer.sv
// Framing convolutional encoder: serial bits in, 2-bit symbols out, 6-bit zero tail.
// Ports: clk, rst, enable/data/valid/last in, ready out, symbol handshake,
// busy_o, word_ct_o, err_inj_o. Option macro: CONV_ENC_ERR_INJ_EN.
module conv_enc_framer
  import viterbi_pkg::*;
#(
  parameter int CT_W = 16
`ifdef CONV_ENC_ERR_INJ_EN
  ,
  parameter int ERR_PERIOD = 37
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_encoder_i,
  input  logic            encoder_i,
  input  logic            encoder_valid_i,
  input  logic            encoder_last_i,
  output logic            encoder_ready_o,
  output logic [1:0]      enc_sym_o,
  output logic            enc_valid_o,
  input  logic            enc_ready_i,
  output logic            busy_o,
  output logic [CT_W-1:0] word_ct_o,
  output logic            err_inj_o
);

  enc_state_e      state_q, state_d;
  logic [2:0]      tail_q, tail_d;
  logic            vld_q;
  sym_t            sym_q, sym_d;
  logic [CT_W-1:0] ct_q;

  logic slot_free;
  logic xfer;
  logic accept;
  logic load;
  logic enc_bit;
  sym_t core_sym;

  assign slot_free = !vld_q || enc_ready_i;
  assign xfer      = vld_q && enc_ready_i;

  // gated by rst so ready reads low while reset is held
  assign encoder_ready_o = rst && enable_encoder_i && slot_free
                           && (state_q != TAIL);

  assign accept  = encoder_valid_i && encoder_ready_o;
  assign load    = accept || ((state_q == TAIL) && slot_free);
  assign enc_bit = (state_q == TAIL) ? 1'b0 : encoder_i;

  conv_enc_core u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (load),
    .bit_i    (enc_bit),
    .sym_o    (core_sym)
  );

  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    unique case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          state_d = encoder_last_i ? TAIL : DATA;
        end
      end
      TAIL: begin
        if (slot_free) begin
          if (tail_q == 3'(TAIL_LEN-1)) begin
            state_d = IDLE;
            tail_d  = 3'd0;
          end else begin
            tail_d = tail_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tail_d  = 3'd0;
      end
    endcase
  end

`ifdef CONV_ENC_ERR_INJ_EN
  logic [9:0] lfsr_q;
  logic [9:0] per_q;
  logic       err_q;
  logic       hit;

  // per_q counts loaded symbols; hit marks every ERR_PERIOD-th one
  assign hit = (per_q == 10'(ERR_PERIOD-1));

  always_comb begin
    sym_d = core_sym;
    if (hit) begin
      sym_d = core_sym ^ (lfsr_q[0] ? 2'b10 : 2'b01);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 10'h001;
      per_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (xfer) begin
        lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      end
      if (load) begin
        per_q <= hit ? 10'd0 : per_q + 10'd1;
        err_q <= hit;
      end
    end
  end

  assign err_inj_o = err_q && vld_q;
`else
  assign sym_d     = core_sym;
  assign err_inj_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tail_q  <= 3'd0;
      vld_q   <= 1'b0;
      sym_q   <= 2'b00;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      if (load) begin
        vld_q <= 1'b1;
        sym_q <= sym_d;
      end else if (enc_ready_i) begin
        vld_q <= 1'b0;
      end
      if (xfer) begin
        ct_q <= ct_q + 1'b1;
      end
    end
  end

  assign enc_valid_o = vld_q;
  assign enc_sym_o   = sym_q;
  assign busy_o      = (state_q != IDLE) || vld_q;
  assign word_ct_o   = ct_q;

endmodule

// File: tb/tb_conv_enc_framer.sv
// Directed bench for conv_enc_framer: impulse, streaming, backpressure,
// enable gating, reset mid-tail and the error-injection zero frame.
module tb_conv_enc_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_encoder_i;
  logic        encoder_i;
  logic        encoder_valid_i;
  logic        encoder_last_i;
  logic        encoder_ready_o;
  logic [1:0]  enc_sym_o;
  logic        enc_valid_o;
  logic        enc_ready_i;
  logic        busy_o;
  logic [15:0] word_ct_o;
  logic        err_inj_o;

  int checks   = 0;
  int failures = 0;
  int exp_ct   = 0;
  int holds    = 0;

  logic [1:0] got[$];
  logic       gerr[$];
  logic [1:0] exp_q[$];
  logic       src[$];

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [1:0] ps = 2'b00;

  always #5 clk = ~clk;

  conv_enc_framer #(.CT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_encoder_i (enable_encoder_i),
    .encoder_i        (encoder_i),
    .encoder_valid_i  (encoder_valid_i),
    .encoder_last_i   (encoder_last_i),
    .encoder_ready_o  (encoder_ready_o),
    .enc_sym_o        (enc_sym_o),
    .enc_valid_o      (enc_valid_o),
    .enc_ready_i      (enc_ready_i),
    .busy_o           (busy_o),
    .word_ct_o        (word_ct_o),
    .err_inj_o        (err_inj_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // record each transfer; it completes on the following rising edge
  always @(negedge clk) begin
    if (rst && enc_valid_o && enc_ready_i) begin
      got.push_back(enc_sym_o);
      gerr.push_back(err_inj_o);
    end
  end

  // a stalled symbol must stay put until it is taken
  always @(negedge clk) begin
    if (rst && pv && !pr) begin
      holds++;
      chk("hold", {enc_valid_o, enc_sym_o}, {1'b1, ps});
    end
    pv = rst && enc_valid_o;
    pr = enc_ready_i;
    ps = enc_sym_o;
  end

  task automatic build_exp();
    logic [5:0] s;
    logic       b;
    s = 6'd0;
    exp_q.delete();
    for (int i = 0; i < src.size() + 6; i++) begin
      b = (i < src.size()) ? src[i] : 1'b0;
      exp_q.push_back({b ^ s[0] ^ s[1] ^ s[2] ^ s[5],
                       b ^ s[1] ^ s[2] ^ s[4] ^ s[5]});
      s = {s[4:0], b};
    end
  endtask

  task automatic cmp(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    end
    chk({tag, "_syms"}, bad, 0);
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_bit(input logic b, input logic l, output int st);
    st = 0;
    encoder_valid_i = 1'b1;
    encoder_i       = b;
    encoder_last_i  = l;
    @(negedge clk);
    while (!encoder_ready_o && st < 200) begin
      @(negedge clk);
      st++;
    end
    if (st >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    encoder_valid_i = 1'b0;
    encoder_last_i  = 1'b0;
  endtask

  task automatic send_src(output int stalls);
    int st;
    stalls = 0;
    for (int i = 0; i < src.size(); i++) begin
      send_bit(src[i], i == src.size() - 1, st);
      stalls += st;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o || enc_valid_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, n < 300, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, enc_valid_o, 0);
    chk({tag, "_sym"}, enc_sym_o, 0);
    chk({tag, "_rdy"}, encoder_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ct"}, word_ct_o, 0);
    chk({tag, "_err"}, err_inj_o, 0);
  endtask

  initial begin
    logic [1:0]  imp[7];
    logic [19:0] pat;
    logic [9:0]  pat2;
    logic [1:0]  bp[4];
    int          st;
    int          n;
    int          nz;
    int          ne;

    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    bp  = '{2'b01, 2'b00, 2'b00, 2'b01};

    rst              = 1'b0;
    enable_encoder_i = 1'b1;
    encoder_i        = 1'b0;
    encoder_valid_i  = 1'b0;
    encoder_last_i   = 1'b0;
    enc_ready_i      = 1'b1;
    #1;
    chk_reset("rst0");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // all-zero 74-bit frame
    got.delete();
    gerr.delete();
    src.delete();
    for (int i = 0; i < 74; i++) src.push_back(1'b0);
    send_src(st);
    wait_idle("zero");
    exp_ct += 80;
    nz = 0;
    ne = 0;
    foreach (got[i]) if (got[i] != 2'b00) nz++;
    foreach (gerr[i]) if (gerr[i]) ne++;
    chk("zero_len", got.size(), 80);
`ifdef CONV_ENC_ERR_INJ_EN
    chk("inj_nonzero", nz, 2);
    chk("inj_flags", ne, 2);
    chk("inj_37", got[36] != 2'b00 && gerr[36], 1);
    chk("inj_74", got[73] != 2'b00 && gerr[73], 1);
`else
    chk("zero_nonzero", nz, 0);
    chk("zero_flags", ne, 0);
`endif
    chk("zero_ct", word_ct_o, exp_ct);

`ifndef CONV_ENC_ERR_INJ_EN
    // impulse
    got.delete();
    send_bit(1'b1, 1'b1, st);
    wait_idle("imp");
    exp_ct += 7;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i >= got.size() || got[i] !== imp[i]) n++;
    end
    chk("imp_len", got.size(), 7);
    chk("imp_syms", n, 0);
    chk("imp_busy", busy_o, 0);
    chk("imp_ct", word_ct_o, exp_ct);

    // streaming 20 bits
    got.delete();
    src.delete();
    pat = 20'hB5E3A;
    for (int i = 19; i >= 0; i--) src.push_back(pat[i]);
    build_exp();
    send_src(st);
    chk("str_stalls", st, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (encoder_ready_o) n++;
    end
    chk("str_tail_rdy_low", n, 0);
    @(negedge clk);
    chk("str_rdy_after_tail", encoder_ready_o, 1);
    wait_idle("str");
    exp_ct += 26;
    cmp("str");
    chk("str_ct", word_ct_o, exp_ct);

    // backpressure on the impulse frame
    got.delete();
    holds = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          enc_ready_i = bp[i % 4][0];
        end
        enc_ready_i = 1'b1;
      end
      begin
        send_bit(1'b1, 1'b1, st);
      end
    join
    wait_idle("bp");
    exp_ct += 7;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i >= got.size() || got[i] !== imp[i]) n++;
    end
    chk("bp_len", got.size(), 7);
    chk("bp_syms", n, 0);
    chk("bp_held", holds > 0, 1);
    chk("bp_ct", word_ct_o, exp_ct);

    // enable gating mid-DATA
    got.delete();
    src.delete();
    pat2 = 10'b1101001110;
    for (int i = 9; i >= 0; i--) src.push_back(pat2[i]);
    build_exp();
    for (int i = 0; i < 5; i++) send_bit(src[i], 1'b0, st);
    encoder_valid_i  = 1'b1;
    encoder_i        = src[5];
    enable_encoder_i = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (encoder_ready_o) n++;
    end
    chk("en_no_accept", n, 0);
    chk("en_drained", enc_valid_o, 0);
    chk("en_busy", busy_o, 1);
    @(posedge clk);
    #1;
    enable_encoder_i = 1'b1;
    for (int i = 5; i < 10; i++) send_bit(src[i], i == 9, st);
    wait_idle("en");
    exp_ct += 16;
    cmp("en");
    chk("en_ct", word_ct_o, exp_ct);

    // reset after the 3rd tail symbol
    got.delete();
    send_bit(1'b1, 1'b1, st);
    n = 0;
    while (got.size() < 4 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rt_reach", got.size(), 4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("rt");
    @(posedge clk);
    #1;
    rst = 1'b1;
    got.delete();
    send_bit(1'b1, 1'b1, st);
    wait_idle("rt2");
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i >= got.size() || got[i] !== imp[i]) n++;
    end
    chk("rt2_len", got.size(), 7);
    chk("rt2_syms", n, 0);
    chk("rt2_ct", word_ct_o, 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
